pipe_ctrl: RTL and testbench

- Central stall/flush/redirect controller for the 5-stage in-order pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Collects hazard requests from decode, multi-cycle operation requests from execute, branch resolutions and exceptions.
- Drives a per-stage stall vector, flush strobes, and a PC redirect (target + valid) into the PC register.
- Holds the sequencing state for multi-cycle execute ops and exception flush windows.

---
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for a 5-stage in-order pipeline.
// Arbitrates exceptions, multi-cycle execute ops, taken branches and load-use hazards.
module pipe_ctrl #(
  parameter int unsigned MC_CNT_W     = 6,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_stallreq_i,
  input  logic                ex_mc_start_i,
  input  logic [MC_CNT_W-1:0] ex_mc_len_i,
  input  logic                br_taken_i,
  input  logic [31:0]         br_target_i,
  input  logic                excp_i,
  input  logic [31:0]         excp_target_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic                br_flush_o,
  output logic                pc_redirect_o,
  output logic [31:0]         new_pc_o,
  output logic                ex_mc_done_o,
  output logic                busy_o
);

  localparam int unsigned FCNT_W    = 4;
  localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_LDU  = 6'b000111;

  typedef enum logic [1:0] {
    S_RUN,
    S_MC_BUSY,
    S_EXCP_FLUSH
  } state_e;

  state_e                state_q, state_d;
  logic [MC_CNT_W-1:0]   cnt_q, cnt_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  flush_q, flush_d;
  logic                  br_flush_q, br_flush_d;
  logic                  redirect_q, redirect_d;
  logic [31:0]           new_pc_q, new_pc_d;
  logic [5:0]            stall_c;
  logic                  mc_done_c;
  logic                  mc_long_c;

  // Length 0 behaves as 1, so only lengths >= 2 enter MC_BUSY.
  assign mc_long_c = ex_mc_len_i > MC_CNT_W'(1);

  // Next-state, flush/redirect sequencing and combinational stall/done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    flush_d    = 1'b0;
    br_flush_d = 1'b0;
    redirect_d = 1'b0;
    new_pc_d   = new_pc_q;
    stall_c    = 6'b000000;
    mc_done_c  = 1'b0;

    case (state_q)
      S_RUN: begin
        if (ex_mc_start_i) begin
          if (mc_long_c) begin
            stall_c = STALL_MC;
            cnt_d   = ex_mc_len_i - MC_CNT_W'(2);
            state_d = S_MC_BUSY;
          end else begin
            mc_done_c = 1'b1;
          end
        end else if (id_stallreq_i) begin
          stall_c = STALL_LDU;
        end
        if (br_taken_i) begin
          redirect_d = 1'b1;
          br_flush_d = 1'b1;
          new_pc_d   = br_target_i;
        end
      end
      S_MC_BUSY: begin
        if (cnt_q != '0) begin
          stall_c = STALL_MC;
          cnt_d   = cnt_q - MC_CNT_W'(1);
        end else begin
          mc_done_c = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_EXCP_FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          fcnt_d  = fcnt_q - FCNT_W'(1);
          flush_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    // Exception overrides everything: aborts MC ops and drops any branch.
    if (excp_i) begin
      state_d    = S_EXCP_FLUSH;
      fcnt_d     = FCNT_INIT;
      cnt_d      = '0;
      flush_d    = 1'b1;
      redirect_d = 1'b1;
      br_flush_d = 1'b0;
      new_pc_d   = excp_target_i;
      mc_done_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      flush_q    <= 1'b0;
      br_flush_q <= 1'b0;
      redirect_q <= 1'b0;
      new_pc_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      flush_q    <= flush_d;
      br_flush_q <= br_flush_d;
      redirect_q <= redirect_d;
      new_pc_q   <= new_pc_d;
    end
  end

  assign stall_o       = rst ? 6'b000000 : stall_c;
  assign ex_mc_done_o  = rst ? 1'b0 : mc_done_c;
  assign flush_o       = flush_q;
  assign br_flush_o    = br_flush_q;
  assign pc_redirect_o = redirect_q;
  assign new_pc_o      = new_pc_q;
  assign busy_o        = state_q != S_RUN;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (1- and 3-cycle flush windows) on shared stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stallreq_i, ex_mc_start_i, br_taken_i, excp_i;
  logic [5:0]  ex_mc_len_i;
  logic [31:0] br_target_i, excp_target_i;

  logic [5:0]  stall_o,  stall3_o;
  logic        flush_o,  flush3_o, br_flush_o, br_flush3_o;
  logic        redir_o,  redir3_o, done_o, done3_o, busy_o, busy3_o;
  logic [31:0] new_pc_o, new_pc3_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MC_CNT_W(6), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .id_stallreq_i(id_stallreq_i), .ex_mc_start_i(ex_mc_start_i),
    .ex_mc_len_i(ex_mc_len_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .excp_i(excp_i), .excp_target_i(excp_target_i), .stall_o(stall_o), .flush_o(flush_o),
    .br_flush_o(br_flush_o), .pc_redirect_o(redir_o), .new_pc_o(new_pc_o),
    .ex_mc_done_o(done_o), .busy_o(busy_o)
  );

  pipe_ctrl #(.MC_CNT_W(6), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .id_stallreq_i(id_stallreq_i), .ex_mc_start_i(ex_mc_start_i),
    .ex_mc_len_i(ex_mc_len_i), .br_taken_i(br_taken_i), .br_target_i(br_target_i),
    .excp_i(excp_i), .excp_target_i(excp_target_i), .stall_o(stall3_o), .flush_o(flush3_o),
    .br_flush_o(br_flush3_o), .pc_redirect_o(redir3_o), .new_pc_o(new_pc3_o),
    .ex_mc_done_o(done3_o), .busy_o(busy3_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs set here apply to the new cycle.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_stallreq_i = 1'b0; ex_mc_start_i = 1'b0; ex_mc_len_i = 6'd0;
    br_taken_i = 1'b0; br_target_i = 32'h0; excp_i = 1'b0; excp_target_i = 32'h0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_stall"}, 32'(stall_o), 32'h0);
    chk({tag, "_redir"}, 32'(redir_o), 32'h0);
    chk({tag, "_brfl"},  32'(br_flush_o), 32'h0);
    chk({tag, "_flush"}, 32'(flush_o), 32'h0);
    chk({tag, "_done"},  32'(done_o), 32'h0);
    chk({tag, "_busy"},  32'(busy_o), 32'h0);
  endtask

  initial begin
    // Reset held two cycles with every request asserted.
    idle_inputs();
    rst = 1'b1; excp_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'hdead0000;
    excp_target_i = 32'hbeef0000; id_stallreq_i = 1'b1; ex_mc_start_i = 1'b1; ex_mc_len_i = 6'd5;
    for (int i = 0; i < 2; i++) begin
      next_cyc(); #2;
      chk_quiet("rst");
      chk("rst_newpc", new_pc_o, 32'h0);
      chk("rst_flush3", 32'(flush3_o), 32'h0);
    end
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rel_stall", 32'(stall_o), 32'h0);
    chk("rel_busy", 32'(busy_o), 32'h0);
    chk("rel_redir", 32'(redir_o), 32'h0);

    // Load-use for two cycles.
    next_cyc(); id_stallreq_i = 1'b1; #2; chk("ldu0_stall", 32'(stall_o), 32'h07);
    next_cyc(); #2;                       chk("ldu1_stall", 32'(stall_o), 32'h07);
    next_cyc(); idle_inputs(); #2;         chk_quiet("ldu_after");

    // Multi-cycle length 5: stall N..N+3, done N+4, busy N+1..N+4.
    next_cyc(); ex_mc_start_i = 1'b1; ex_mc_len_i = 6'd5; #2;
    chk("mc5_n_stall", 32'(stall_o), 32'h0f);
    chk("mc5_n_done", 32'(done_o), 32'h0);
    chk("mc5_n_busy", 32'(busy_o), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      next_cyc(); idle_inputs(); id_stallreq_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h1111;
      #2;
      chk($sformatf("mc5_n%0d_stall", k), 32'(stall_o), 32'h0f);
      chk($sformatf("mc5_n%0d_done", k), 32'(done_o), 32'h0);
      chk($sformatf("mc5_n%0d_busy", k), 32'(busy_o), 32'h1);
    end
    next_cyc(); idle_inputs(); #2;
    chk("mc5_n4_stall", 32'(stall_o), 32'h0);
    chk("mc5_n4_done", 32'(done_o), 32'h1);
    chk("mc5_n4_busy", 32'(busy_o), 32'h1);
    chk("mc5_n4_redir", 32'(redir_o), 32'h0);
    next_cyc(); #2; chk_quiet("mc5_n5");

    // Lengths 1 and 0: done in the start cycle, no stall.
    for (int l = 1; l >= 0; l--) begin
      next_cyc(); ex_mc_start_i = 1'b1; ex_mc_len_i = 6'(l); #2;
      chk($sformatf("mc%0d_stall", l), 32'(stall_o), 32'h0);
      chk($sformatf("mc%0d_done", l), 32'(done_o), 32'h1);
      next_cyc(); idle_inputs(); #2;
      chk_quiet($sformatf("mc%0d_after", l));
    end

    // Taken branch.
    next_cyc(); br_taken_i = 1'b1; br_target_i = 32'h1c000040; #2;
    chk("br_n_redir", 32'(redir_o), 32'h0);
    next_cyc(); idle_inputs(); #2;
    chk("br_n1_redir", 32'(redir_o), 32'h1);
    chk("br_n1_brfl", 32'(br_flush_o), 32'h1);
    chk("br_n1_flush", 32'(flush_o), 32'h0);
    chk("br_n1_pc", new_pc_o, 32'h1c000040);
    next_cyc(); #2; chk_quiet("br_n2");

    // Branch together with load-use: stall now, redirect next.
    next_cyc(); br_taken_i = 1'b1; br_target_i = 32'h00000800; id_stallreq_i = 1'b1; #2;
    chk("brldu_stall", 32'(stall_o), 32'h07);
    next_cyc(); idle_inputs(); #2;
    chk("brldu_redir", 32'(redir_o), 32'h1);
    chk("brldu_pc", new_pc_o, 32'h00000800);

    // Branch together with MC start (len 3): both honoured.
    next_cyc(); br_taken_i = 1'b1; br_target_i = 32'h00000c00; ex_mc_start_i = 1'b1;
    ex_mc_len_i = 6'd3; #2;
    chk("brmc_n_stall", 32'(stall_o), 32'h0f);
    next_cyc(); idle_inputs(); #2;
    chk("brmc_n1_stall", 32'(stall_o), 32'h0f);
    chk("brmc_n1_redir", 32'(redir_o), 32'h1);
    chk("brmc_n1_brfl", 32'(br_flush_o), 32'h1);
    chk("brmc_n1_pc", new_pc_o, 32'h00000c00);
    next_cyc(); #2;
    chk("brmc_n2_done", 32'(done_o), 32'h1);
    chk("brmc_n2_redir", 32'(redir_o), 32'h0);
    next_cyc(); #2; chk_quiet("brmc_n3");

    // Exception aborts MC len 10 at N+3.
    next_cyc(); ex_mc_start_i = 1'b1; ex_mc_len_i = 6'd10; #2;
    chk("xmc_n_stall", 32'(stall_o), 32'h0f);
    next_cyc(); idle_inputs(); #2; chk("xmc_n1_done", 32'(done_o), 32'h0);
    next_cyc(); #2;                chk("xmc_n2_done", 32'(done_o), 32'h0);
    next_cyc(); excp_i = 1'b1; excp_target_i = 32'h1c008000; #2;
    chk("xmc_n3_done", 32'(done_o), 32'h0);
    next_cyc(); idle_inputs(); #2;
    chk("xmc_n4_redir", 32'(redir_o), 32'h1);
    chk("xmc_n4_pc", new_pc_o, 32'h1c008000);
    chk("xmc_n4_flush", 32'(flush_o), 32'h1);
    chk("xmc_n4_brfl", 32'(br_flush_o), 32'h0);
    chk("xmc_n4_stall", 32'(stall_o), 32'h0);
    chk("xmc_n4_done", 32'(done_o), 32'h0);
    chk("xmc_n4_busy", 32'(busy_o), 32'h1);
    chk("xmc_n4_flush3", 32'(flush3_o), 32'h1);
    chk("xmc_n4_pc3", new_pc3_o, 32'h1c008000);
    next_cyc(); #2;
    chk("xmc_n5_flush", 32'(flush_o), 32'h0);
    chk("xmc_n5_busy", 32'(busy_o), 32'h0);
    chk("xmc_n5_redir", 32'(redir_o), 32'h0);
    chk("xmc_n5_done", 32'(done_o), 32'h0);
    chk("xmc_n5_flush3", 32'(flush3_o), 32'h1);
    chk("xmc_n5_redir3", 32'(redir3_o), 32'h0);
    chk("xmc_n5_stall3", 32'(stall3_o), 32'h0);
    next_cyc(); #2;
    chk("xmc_n6_flush3", 32'(flush3_o), 32'h1);
    chk("xmc_n6_busy3", 32'(busy3_o), 32'h1);
    chk("xmc_n6_done3", 32'(done3_o), 32'h0);
    next_cyc(); #2;
    chk("xmc_n7_flush3", 32'(flush3_o), 32'h0);
    chk("xmc_n7_busy3", 32'(busy3_o), 32'h0);
    chk("xmc_n7_done", 32'(done_o), 32'h0);

    // Exception with simultaneous branch, then a second exception inside the window.
    next_cyc(); excp_i = 1'b1; excp_target_i = 32'h80000100;
    br_taken_i = 1'b1; br_target_i = 32'h40000200; #2;
    next_cyc(); idle_inputs(); excp_i = 1'b1; excp_target_i = 32'h80000300; #2;
    chk("col_m1_redir", 32'(redir_o), 32'h1);
    chk("col_m1_pc", new_pc_o, 32'h80000100);
    chk("col_m1_brfl", 32'(br_flush_o), 32'h0);
    chk("col_m1_flush", 32'(flush_o), 32'h1);
    chk("col_m1_pc3", new_pc3_o, 32'h80000100);
    next_cyc(); idle_inputs(); br_taken_i = 1'b1; br_target_i = 32'h40000400; #2;
    chk("col_m2_redir3", 32'(redir3_o), 32'h1);
    chk("col_m2_pc3", new_pc3_o, 32'h80000300);
    chk("col_m2_flush3", 32'(flush3_o), 32'h1);
    chk("col_m2_pc", new_pc_o, 32'h80000300);
    chk("col_m2_brfl3", 32'(br_flush3_o), 32'h0);
    next_cyc(); idle_inputs(); #2;
    chk("col_m3_redir3", 32'(redir3_o), 32'h0);
    chk("col_m3_brfl3", 32'(br_flush3_o), 32'h0);
    chk("col_m3_flush3", 32'(flush3_o), 32'h1);
    chk("col_m3_redir", 32'(redir_o), 32'h0);
    chk("col_m3_brfl", 32'(br_flush_o), 32'h0);
    chk("col_m3_pc3", new_pc3_o, 32'h80000300);
    next_cyc(); #2; chk("col_m4_flush3", 32'(flush3_o), 32'h1);
    next_cyc(); #2;
    chk("col_m5_flush3", 32'(flush3_o), 32'h0);
    chk("col_m5_busy3", 32'(busy3_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
